// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits) with a Moore
// detect output. Define SEQ_DET_HIT_COUNT_EN to build the saturating hit counter.
module seq_pattern_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'h0B,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  parameter int                 CNT_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seq_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               det_o,
  output logic [CNT_W-1:0]   hit_count,
  output logic               cfg_err
);

  typedef enum logic [1:0] {UNCFG, HUNT, HIT} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               cfg_err_q, cfg_err_d;

  logic [MAX_LEN-1:0] hist_upd;
  logic [LEN_W-1:0]   fill_upd;
  logic [MAX_LEN-1:0] len_mask;
  logic               accept;
  logic               match;
  logic               cfg_legal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign accept    = in_valid && !cfg_load && (state_q != UNCFG);
  assign hist_upd  = {hist_q[MAX_LEN-2:0], seq_in};
  assign fill_upd  = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    len_mask  = '0;
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cfg_err_d = cfg_err_q;

    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = accept && (fill_upd == len_q) &&
            (((hist_upd ^ pattern_q) & len_mask) == '0);

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      cfg_err_d = !cfg_legal;
      state_d   = cfg_legal ? HUNT : UNCFG;
    end else begin
      if (accept) begin
        hist_d = hist_upd;
        fill_d = fill_upd;
      end
      if (match) begin
        state_d = HIT;
        // Non-overlap mode needs a full window of fresh bits before the next hit.
        if (!overlap_q) fill_d = '0;
      end else if (state_q == HIT) begin
        state_d = HUNT;
      end
    end
  end

  assign det_o   = (state_q == HIT);
  assign cfg_err = cfg_err_q;

`ifdef SEQ_DET_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cfg_load) begin
      cnt_q <= '0;
    end else if (match && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit_count = cnt_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed scenarios plus random
// traffic compared against a queue-based model of the bit stream.
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               seq_in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               det_o;
  logic [CNT_W-1:0]   hit_count;
  logic               cfg_err;

  seq_pattern_detector #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DEF_PATTERN(8'h0B),
    .DEF_LEN(4), .DEF_OVERLAP(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .seq_in(seq_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .det_o(det_o), .hit_count(hit_count),
    .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the accepted bits since the last restart, oldest first.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl, m_uncfg, m_err, m_det;
  int                 m_cnt;
  bit                 m_bits[$];

  task automatic m_reset();
    m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
    m_uncfg = 1'b0; m_err = 1'b0; m_det = 1'b0; m_cnt = 0;
    m_bits.delete();
  endtask

  task automatic m_step(input bit ld, input bit v, input bit b,
                        input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
    bit hit;
    if (ld) begin
      m_pat = pat; m_len = len; m_ovl = ovl;
      m_bits.delete();
      m_err   = !(len >= 1 && len <= MAX_LEN);
      m_uncfg = m_err;
      m_det   = 1'b0;
      m_cnt   = 0;
    end else if (v && !m_uncfg) begin
      m_bits.push_back(b);
      if (m_bits.size() > m_len) void'(m_bits.pop_front());
      hit = (m_bits.size() == m_len);
      for (int k = 0; k < m_len && hit; k++)
        if (m_bits[k] != m_pat[m_len-1-k]) hit = 1'b0;
      m_det = hit;
      if (hit) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) m_bits.delete();
      end
    end else begin
      m_det = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef SEQ_DET_HIT_COUNT_EN
    return 32'(m_cnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".det"}, 32'(det_o), 32'(m_det));
    check({tag, ".err"}, 32'(cfg_err), 32'(m_err));
    check({tag, ".cnt"}, 32'(hit_count), exp_count());
  endtask

  // Called at a falling edge: drive, clock once, sample 1 time unit after the edge.
  task automatic apply(input string tag, input bit ld, input bit v, input bit b,
                       input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
    cfg_load = ld; in_valid = v; seq_in = b;
    cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    m_step(ld, v, b, pat, len, ovl);
    @(posedge clock);
    #1;
    check_outputs(tag);
    @(negedge clock);
  endtask

  task automatic bit_in(input string tag, input bit v, input bit b);
    apply(tag, 1'b0, v, b, 8'($urandom), int'($urandom_range(0, 15)), 1'($urandom));
  endtask

  task automatic load(input string tag, input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
    apply(tag, 1'b1, 1'($urandom), 1'($urandom), pat, len, ovl);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  bit stream_a[7] = '{1, 0, 1, 1, 0, 1, 1};
  bit stream_b[5] = '{1, 0, 1, 0, 1};

  initial begin
    reset = 1'b0; seq_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    @(negedge clock);
    do_reset();
    check_outputs("reset");

    // Default pattern 1011, overlapping: hits after bits 4 and 7.
    foreach (stream_a[i]) bit_in("t1", 1'b1, stream_a[i]);

    // 101 non-overlap then overlap on the same stream.
    load("t2.ld", 8'b101, 3, 1'b0);
    foreach (stream_b[i]) bit_in("t2.novl", 1'b1, stream_b[i]);
    load("t2.ld2", 8'b101, 3, 1'b1);
    foreach (stream_b[i]) bit_in("t2.ovl", 1'b1, stream_b[i]);

    // 1011 with invalid gaps and a toggling seq_in during them.
    load("t3.ld", 8'h0B, 4, 1'b1);
    bit_in("t3", 1'b1, 1'b1);
    bit_in("t3", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) bit_in("t3.gap", 1'b0, 1'(i));
    bit_in("t3", 1'b1, 1'b1);
    bit_in("t3", 1'b1, 1'b1);
    bit_in("t3.after", 1'b0, 1'b1);

    // Illegal lengths lock out detection until a legal load.
    load("t4.len0", 8'h0B, 0, 1'b1);
    foreach (stream_a[i]) bit_in("t4.uncfg0", 1'b1, stream_a[i]);
    load("t4.len9", 8'h0B, 9, 1'b1);
    foreach (stream_a[i]) bit_in("t4.uncfg9", 1'b1, stream_a[i]);
    load("t4.legal", 8'h0B, 4, 1'b1);
    foreach (stream_a[i]) bit_in("t4.resume", 1'b1, stream_a[i]);

    // Load coincides with the final matching bit: no hit.
    bit_in("t5", 1'b1, 1'b1);
    bit_in("t5", 1'b1, 1'b0);
    bit_in("t5", 1'b1, 1'b1);
    apply("t5.ld", 1'b1, 1'b1, 1'b1, 8'h0B, 4, 1'b1);
    bit_in("t5.post", 1'b1, 1'b1);

    // Asynchronous reset while det_o is high, then a partial pattern.
    for (int i = 0; i < 4; i++) bit_in("t6.pre", 1'b1, stream_a[i]);
    #2 reset = 1'b1;
    #1 check("t6.async_det", 32'(det_o), 32'd0);
    check("t6.async_cnt", 32'(hit_count), 32'd0);
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) bit_in("t6.part", 1'b1, stream_a[i]);
    #2 reset = 1'b1;
    #1 check("t6.async2", 32'(det_o), 32'd0);
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    bit_in("t6.lone", 1'b1, 1'b1);

    // Single-bit pattern: every 1 is a hit, driving the counter into saturation.
    load("sat.ld", 8'h01, 1, 1'b1);
    for (int i = 0; i < (1 << CNT_W) + 4; i++) bit_in("sat", 1'b1, 1'b1);
    bit_in("sat.zero", 1'b1, 1'b0);

    // Random traffic with occasional (sometimes illegal) reconfiguration.
    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        int len = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(0, 15));
        load("rnd.ld", 8'($urandom), len, 1'($urandom));
      end else begin
        bit_in("rnd", r < 80, 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
